ws281x_bit_seq: RTL and testbench

- Bit-level sequencer for a WS281x LED chain.
- Accepts 24-bit pixel words over a valid/ready handshake and serialises them MSB first onto the single-wire LED output.
- Times each bit's high and low phases from the programmable T0H/T0L/T1H/T1L cycle counts, then holds the line low for a programmable latch (reset) period after the last pixel of a frame.
- Sits between the pixel fetch/buffer logic and the output pin. Drives the per-bit strobe (bit_rdy_out/bit_data_out) consumed by the timing-configuration logic.

---
 rtl/ws281x_bit_seq.sv | 162 ++++++++++++++++
 tb/tb_ws281x_bit_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ws281x_bit_seq.sv
// WS281x bit sequencer: serialises 24-bit pixel words MSB first with programmable
// high/low phase timing and a trailing latch (reset) period after the frame's last pixel.
module ws281x_bit_seq #(
  parameter int unsigned PIX_BITS = 24,
  parameter int unsigned LATCH_W  = 16
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                pix_vld_in,
  input  logic [PIX_BITS-1:0] pix_data_in,
  input  logic                pix_last_in,
  output logic                pix_rdy_out,
  input  logic [7:0]          t0h_cnt_in,
  input  logic [7:0]          t0l_cnt_in,
  input  logic [7:0]          t1h_cnt_in,
  input  logic [7:0]          t1l_cnt_in,
  input  logic [LATCH_W-1:0]  latch_cnt_in,
  output logic                bit_rdy_out,
  output logic                bit_data_out,
  output logic                ws281x_out,
  output logic                busy_out,
  output logic                done_out
);

  localparam int unsigned CW = (LATCH_W > 8) ? LATCH_W : 8;
  localparam int unsigned IW = (PIX_BITS > 1) ? $clog2(PIX_BITS) : 1;

  typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_e;

  state_e              state_q, state_d;
  logic [PIX_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                last_q, last_d;
  logic                done_q, done_d;
  logic                ws_q, ws_d;
  logic                brdy_q, brdy_d;
  logic                bdat_q, bdat_d;
  logic                busy_q, busy_d;
  logic                cur_bit, phase_end, last_bit, accept;

  // Counter holds remaining cycles minus one, so a programmed 0 still yields one cycle.
  function automatic logic [CW-1:0] len_m1(input logic [CW-1:0] n);
    return (n == '0) ? '0 : n - CW'(1);
  endfunction

  function automatic logic [CW-1:0] hi_len(input logic b, input logic [7:0] h1,
                                           input logic [7:0] h0);
    return len_m1(b ? CW'(h1) : CW'(h0));
  endfunction

  always_comb begin
    cur_bit     = shift_q[PIX_BITS-1];
    phase_end   = (cnt_q == '0);
    last_bit    = (idx_q == '0);
    pix_rdy_out = !rst_in && ((state_q == IDLE) ||
                  ((state_q == LOW) && phase_end && last_bit && !last_q));
    accept      = pix_vld_in && pix_rdy_out;

    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    done_d  = 1'b0;
    brdy_d  = 1'b0;
    bdat_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = HIGH;
          shift_d = pix_data_in;
          last_d  = pix_last_in;
          idx_d   = IW'(PIX_BITS - 1);
          cnt_d   = hi_len(pix_data_in[PIX_BITS-1], t1h_cnt_in, t0h_cnt_in);
          brdy_d  = 1'b1;
          bdat_d  = pix_data_in[PIX_BITS-1];
        end
      end
      HIGH: begin
        if (phase_end) begin
          state_d = LOW;
          cnt_d   = len_m1(cur_bit ? CW'(t1l_cnt_in) : CW'(t0l_cnt_in));
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      LOW: begin
        if (!phase_end) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!last_bit) begin
          state_d = HIGH;
          shift_d = shift_q << 1;
          idx_d   = idx_q - IW'(1);
          cnt_d   = hi_len(shift_q[PIX_BITS-2], t1h_cnt_in, t0h_cnt_in);
          brdy_d  = 1'b1;
          bdat_d  = shift_q[PIX_BITS-2];
        end else if (accept) begin
          // Gapless hand-off: next pixel's MSB starts right after this bit's low phase.
          state_d = HIGH;
          shift_d = pix_data_in;
          last_d  = pix_last_in;
          idx_d   = IW'(PIX_BITS - 1);
          cnt_d   = hi_len(pix_data_in[PIX_BITS-1], t1h_cnt_in, t0h_cnt_in);
          brdy_d  = 1'b1;
          bdat_d  = pix_data_in[PIX_BITS-1];
        end else if (last_q) begin
          state_d = LATCH;
          cnt_d   = len_m1(CW'(latch_cnt_in));
        end else begin
          state_d = IDLE;
        end
      end
      LATCH: begin
        if (phase_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    ws_d   = (state_d == HIGH);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      ws_q    <= 1'b0;
      brdy_q  <= 1'b0;
      bdat_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      done_q  <= done_d;
      ws_q    <= ws_d;
      brdy_q  <= brdy_d;
      bdat_q  <= bdat_d;
      busy_q  <= busy_d;
    end
  end

  assign ws281x_out   = ws_q;
  assign bit_rdy_out  = brdy_q;
  assign bit_data_out = bdat_q;
  assign busy_out     = busy_q;
  assign done_out     = done_q;

endmodule

// File: tb/tb_ws281x_bit_seq.sv
// Directed bench for ws281x_bit_seq: checks line waveform, bit strobes, handshake and latch/done.
module tb_ws281x_bit_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic [23:0] data;
  logic        last;
  logic        pix_rdy;
  logic [7:0]  t0h, t0l, t1h, t1l;
  logic [15:0] latch;
  logic        bit_rdy, bit_data, ws, busy, done;

  int vec = 0;
  int mis = 0;

  logic wv[$];
  logic rv[$];
  logic dv[$];
  logic pv[$];

  ws281x_bit_seq #(.PIX_BITS(24), .LATCH_W(16)) dut (
    .clk_in(clk), .rst_in(rst), .pix_vld_in(vld), .pix_data_in(data),
    .pix_last_in(last), .pix_rdy_out(pix_rdy), .t0h_cnt_in(t0h), .t0l_cnt_in(t0l),
    .t1h_cnt_in(t1h), .t1l_cnt_in(t1l), .latch_cnt_in(latch), .bit_rdy_out(bit_rdy),
    .bit_data_out(bit_data), .ws281x_out(ws), .busy_out(busy), .done_out(done)
  );

  always #5 clk = ~clk;

  task automatic set_counts(input logic [7:0] a, b, c, d, input logic [15:0] l);
    t0h = a; t0l = b; t1h = c; t1l = d; latch = l;
  endtask

  task automatic clear_wave();
    wv.delete(); rv.delete(); dv.delete(); pv.delete();
  endtask

  // Expected per-cycle line/strobe/ready pattern for one pixel, MSB first.
  task automatic build_wave(input logic [23:0] px, input logic lst);
    int h, l;
    logic b;
    for (int i = 23; i >= 0; i--) begin
      b = px[i];
      h = b ? int'(t1h) : int'(t0h); if (h == 0) h = 1;
      l = b ? int'(t1l) : int'(t0l); if (l == 0) l = 1;
      for (int k = 0; k < h; k++) begin
        wv.push_back(1'b1); rv.push_back(k == 0); dv.push_back(b); pv.push_back(1'b0);
      end
      for (int k = 0; k < l; k++) begin
        wv.push_back(1'b0); rv.push_back(1'b0); dv.push_back(b);
        pv.push_back((i == 0) && (k == l - 1) && !lst);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = 1'b0; data = '0; last = 1'b0;
    set_counts(8'd2, 8'd5, 8'd5, 8'd2, 16'd10);
    #2;
    vec++; if ({ws, bit_rdy, bit_data, busy, done, pix_rdy} !== 6'b0) begin
      mis++; $display("FAIL reset_early outs=%b expected=000000", {ws, bit_rdy, bit_data, busy, done, pix_rdy});
    end
    @(posedge clk); #1;
    vec++; if ({ws, bit_rdy, bit_data, busy, done, pix_rdy} !== 6'b0) begin
      mis++; $display("FAIL reset_held outs=%b expected=000000", {ws, bit_rdy, bit_data, busy, done, pix_rdy});
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    vec++; if ({pix_rdy, ws, bit_rdy, busy, done} !== 5'b10000) begin
      mis++; $display("FAIL reset_release rdy,ws,brdy,busy,done=%b expected=10000", {pix_rdy, ws, bit_rdy, busy, done});
    end
  endtask

  // Scenario: one pixel with last=1 through its bits, the latch period and done.
  task automatic test_frame(input string nm, input logic [23:0] px);
    int pulses, nl;
    clear_wave();
    build_wave(px, 1'b1);
    nl = (latch == 16'd0) ? 1 : int'(latch);
    vec++; if (pix_rdy !== 1'b1) begin
      mis++; $display("FAIL %s.idle_rdy got=%b expected=1", nm, pix_rdy);
    end
    vld = 1'b1; data = px; last = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0;
    pulses = 0;
    for (int c = 0; c < wv.size(); c++) begin
      vec++; if (ws !== wv[c] || busy !== 1'b1 || done !== 1'b0 || pix_rdy !== pv[c]) begin
        mis++; $display("FAIL %s.line c=%0d ws=%b busy=%b done=%b rdy=%b expected ws=%b busy=1 done=0 rdy=%b",
                        nm, c, ws, busy, done, pix_rdy, wv[c], pv[c]);
      end
      vec++; if (bit_rdy !== rv[c] || (rv[c] && bit_data !== dv[c])) begin
        mis++; $display("FAIL %s.strobe c=%0d bit_rdy=%b bit_data=%b expected bit_rdy=%b bit_data=%b",
                        nm, c, bit_rdy, bit_data, rv[c], dv[c]);
      end
      if (bit_rdy === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    vec++; if (pulses != 24) begin
      mis++; $display("FAIL %s.pulses got=%0d expected=24", nm, pulses);
    end
    for (int c = 0; c < nl; c++) begin
      vec++; if ({ws, busy, done, pix_rdy, bit_rdy} !== 5'b01000) begin
        mis++; $display("FAIL %s.latch c=%0d ws,busy,done,rdy,brdy=%b expected=01000", nm, c, {ws, busy, done, pix_rdy, bit_rdy});
      end
      @(posedge clk); #1;
    end
    vec++; if ({done, busy, pix_rdy, ws} !== 4'b1010) begin
      mis++; $display("FAIL %s.done done,busy,rdy,ws=%b expected=1010", nm, {done, busy, pix_rdy, ws});
    end
    @(posedge clk); #1;
    vec++; if (done !== 1'b0) begin
      mis++; $display("FAIL %s.done_pulse got=%b expected=0", nm, done);
    end
  endtask

  task automatic test_single_pixel();
    set_counts(8'd2, 8'd5, 8'd5, 8'd2, 16'd10);
    test_frame("single", 24'h800001);
  endtask

  task automatic test_zero_counts();
    set_counts(8'd0, 8'd0, 8'd3, 8'd1, 16'd0);
    test_frame("zero", 24'h000000);
  endtask

  task automatic test_back_to_back();
    int pulses;
    set_counts(8'd2, 8'd5, 8'd5, 8'd2, 16'd10);
    clear_wave();
    build_wave(24'hA5F00F, 1'b0);
    build_wave(24'h0F1234, 1'b1);
    vld = 1'b1; data = 24'hA5F00F; last = 1'b0;
    @(posedge clk); #1;
    data = 24'h0F1234; last = 1'b1;
    pulses = 0;
    for (int c = 0; c < wv.size(); c++) begin
      vec++; if (ws !== wv[c] || busy !== 1'b1 || done !== 1'b0 || pix_rdy !== pv[c]) begin
        mis++; $display("FAIL b2b.line c=%0d ws=%b busy=%b done=%b rdy=%b expected ws=%b busy=1 done=0 rdy=%b",
                        c, ws, busy, done, pix_rdy, wv[c], pv[c]);
      end
      vec++; if (bit_rdy !== rv[c] || (rv[c] && bit_data !== dv[c])) begin
        mis++; $display("FAIL b2b.strobe c=%0d bit_rdy=%b bit_data=%b expected bit_rdy=%b bit_data=%b",
                        c, bit_rdy, bit_data, rv[c], dv[c]);
      end
      if (bit_rdy === 1'b1) pulses++;
      if (c == 168) vld = 1'b0;
      @(posedge clk); #1;
    end
    vec++; if (pulses != 48) begin
      mis++; $display("FAIL b2b.pulses got=%0d expected=48", pulses);
    end
    for (int c = 0; c < 10; c++) begin
      vec++; if ({ws, busy, done, pix_rdy} !== 4'b0100) begin
        mis++; $display("FAIL b2b.latch c=%0d ws,busy,done,rdy=%b expected=0100", c, {ws, busy, done, pix_rdy});
      end
      @(posedge clk); #1;
    end
    vec++; if ({done, busy} !== 2'b10) begin
      mis++; $display("FAIL b2b.done done,busy=%b expected=10", {done, busy});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_vld_drop();
    set_counts(8'd1, 8'd2, 8'd2, 8'd1, 16'd4);
    clear_wave();
    build_wave(24'h000003, 1'b0);
    vld = 1'b1; data = 24'h000003; last = 1'b0;
    @(posedge clk); #1;
    vld = 1'b0;
    for (int c = 0; c < wv.size(); c++) begin
      vec++; if (ws !== wv[c] || done !== 1'b0 || pix_rdy !== pv[c] || (rv[c] && bit_data !== dv[c])) begin
        mis++; $display("FAIL drop.line c=%0d ws=%b done=%b rdy=%b bit_data=%b expected ws=%b done=0 rdy=%b bit_data=%b",
                        c, ws, done, pix_rdy, bit_data, wv[c], pv[c], dv[c]);
      end
      @(posedge clk); #1;
    end
    for (int c = 0; c < 5; c++) begin
      vec++; if ({ws, pix_rdy, busy, done, bit_rdy} !== 5'b01000) begin
        mis++; $display("FAIL drop.idle c=%0d ws,rdy,busy,done,brdy=%b expected=01000", c, {ws, pix_rdy, busy, done, bit_rdy});
      end
      @(posedge clk); #1;
    end
    test_frame("restart", 24'h800001);
  endtask

  task automatic test_reset_mid_frame();
    set_counts(8'd2, 8'd5, 8'd5, 8'd2, 16'd10);
    vld = 1'b1; data = 24'hFFFFFF; last = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0;
    // Bit 10 is the 14th bit sent; each bit is 7 cycles, so cycle 92 is inside its high phase.
    repeat (92) @(posedge clk);
    #1;
    vec++; if ({ws, busy} !== 2'b11) begin
      mis++; $display("FAIL rstmid.pre ws,busy=%b expected=11", {ws, busy});
    end
    #2 rst = 1'b1;
    #1;
    vec++; if ({ws, busy, bit_rdy, pix_rdy, done} !== 5'b0) begin
      mis++; $display("FAIL rstmid.async ws,busy,brdy,rdy,done=%b expected=00000", {ws, busy, bit_rdy, pix_rdy, done});
    end
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    vec++; if ({pix_rdy, busy, ws} !== 3'b100) begin
      mis++; $display("FAIL rstmid.idle rdy,busy,ws=%b expected=100", {pix_rdy, busy, ws});
    end
    for (int c = 0; c < 30; c++) begin
      vec++; if ({done, ws, bit_rdy} !== 3'b000) begin
        mis++; $display("FAIL rstmid.quiet c=%0d done,ws,brdy=%b expected=000", c, {done, ws, bit_rdy});
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_back_to_back();
    test_zero_counts();
    test_vld_drop();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
